// File: rtl/piezo_seq_pkg.sv
// Shared types and helpers for the piezo melody sequencer.
package piezo_seq_pkg;

  localparam int NUM_TONES = 13;
  localparam logic [3:0] REST_CODE = 4'd13;

  typedef logic [3:0] tone_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  // Codes at or above REST_CODE are rests and map to an all-zero bus.
  function automatic logic [NUM_TONES-1:0] tone_onehot(input tone_code_t code);
    logic [NUM_TONES-1:0] v;
    v = '0;
    if (code < REST_CODE) v = {{(NUM_TONES-1){1'b0}}, 1'b1} << code;
    return v;
  endfunction

endpackage

// File: rtl/piezo_seq_tick.sv
// Divide-by-DIV unit counter with synchronous clear; pulses o_unit_tick on the
// last cycle of each DIV-cycle window while enabled.
module piezo_seq_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_unit_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_unit_tick = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/piezo_melody_seq.sv
// Melody sequencer: steps a note table and drives a one-hot piezo tone bus.
// Define PIEZO_SEQ_GAP_EN to insert GAP_CYCLES of silence after every note.
module piezo_melody_seq
  import piezo_seq_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH),
  parameter int DW         = 4,
  parameter int TICK_DIV   = 250000,
  parameter int GAP_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [3:0]           wr_note,
  input  logic [DW-1:0]        wr_dur,
  input  logic [AW:0]          num_notes,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 loop,
  output logic [NUM_TONES-1:0] playSound,
  output logic                 busy,
  output logic [AW-1:0]        note_idx,
  output logic                 done
);

`ifdef PIEZO_SEQ_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam int WW = 4 + DW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [WW-1:0] r_mem [DEPTH];
  logic [WW-1:0] r_rd_word;

  seq_state_t    r_state, w_state_nxt;
  logic [AW-1:0] r_idx, w_idx_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic [DW-1:0] r_units, w_units_nxt;
  logic          r_done, w_done_nxt;

  logic          w_unit_tick, w_gap_tick, w_decide, w_last;
  tone_code_t    w_note;
  logic [DW-1:0] w_dur, w_dur_eff;

  assign busy     = (r_state != IDLE);
  assign note_idx = r_idx;
  assign done     = r_done;

  // Writes land before the FETCH read, so a write issued with start is seen.
  always_ff @(posedge clk) begin
    if (wr_en && !busy) r_mem[wr_addr] <= {wr_note, wr_dur};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_word <= '0;
    end else if (r_state == FETCH) begin
      r_rd_word <= r_mem[r_idx];
    end
  end

  assign w_note    = r_rd_word[WW-1:DW];
  assign w_dur     = r_rd_word[DW-1:0];
  assign w_dur_eff = (w_dur == '0) ? DW'(1) : w_dur;
  assign w_last    = ({1'b0, r_idx} == (r_len - 1'b1));

  piezo_seq_tick #(.DIV(TICK_DIV)) u_unit_tick (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state != PLAY),
    .i_en        (r_state == PLAY),
    .o_unit_tick (w_unit_tick)
  );

  piezo_seq_tick #(.DIV(GAP_CYCLES)) u_gap_tick (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (r_state != GAP),
    .i_en        (GAP_EN && (r_state == GAP)),
    .o_unit_tick (w_gap_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_units_nxt = r_units;
    w_done_nxt  = 1'b0;
    w_decide    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (num_notes != '0)) begin
          w_len_nxt   = (num_notes > DEPTH_L) ? DEPTH_L : num_notes;
          w_idx_nxt   = '0;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_units_nxt = '0;
        w_state_nxt = PLAY;
      end
      PLAY: begin
        if (w_unit_tick) begin
          if (r_units == (w_dur_eff - 1'b1)) begin
            if (GAP_EN) w_state_nxt = GAP;
            else        w_decide    = 1'b1;
          end else begin
            w_units_nxt = r_units + 1'b1;
          end
        end
      end
      GAP: begin
        if (w_gap_tick) w_decide = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase

    // End-of-note decision; loop is sampled on this cycle only.
    if (w_decide) begin
      if (!w_last) begin
        w_idx_nxt   = r_idx + 1'b1;
        w_state_nxt = FETCH;
      end else if (loop) begin
        w_idx_nxt   = '0;
        w_state_nxt = FETCH;
      end else begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
    end

    if (stop) begin
      w_state_nxt = IDLE;
      w_idx_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_units <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
      r_units <= w_units_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign playSound = (r_state == PLAY) ? tone_onehot(w_note) : '0;

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Bench for piezo_melody_seq: note tables drive a per-cycle expected trace
// (done, busy, playSound, note_idx) that is popped and compared every cycle.
module tb_piezo_melody_seq;

  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int DW      = 4;
  localparam int TICK    = 4;
  localparam int GAP_CYC = 3;
`ifdef PIEZO_SEQ_GAP_EN
  localparam int GAP_LEN = GAP_CYC;
`else
  localparam int GAP_LEN = 0;
`endif
  // {chk_idx, done, busy, playSound[12:0], note_idx[AW-1:0]}
  localparam int EW = 3 + 13 + AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_note = '0;
  logic [DW-1:0] wr_dur = '0;
  logic [AW:0]   num_notes = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [12:0]   playSound;
  logic          busy;
  logic [AW-1:0] note_idx;
  logic          done;

  always #5 clk = ~clk;

  piezo_melody_seq #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .TICK_DIV(TICK), .GAP_CYCLES(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
    .wr_dur(wr_dur), .num_notes(num_notes), .start(start), .stop(stop),
    .loop(loop), .playSound(playSound), .busy(busy), .note_idx(note_idx),
    .done(done)
  );

  typedef struct {
    logic [3:0]    note;
    logic [DW-1:0] dur;
    logic [12:0]   exp_ps;
  } vec_t;

  vec_t          tbl [DEPTH];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  function automatic logic [EW-1:0] mk(input logic c, input logic d, input logic b,
                                       input logic [12:0] ps, input int idx);
    return {c, d, b, ps, AW'(idx)};
  endfunction

  task automatic check_word(input string name, input logic [EW-1:0] exp);
    logic [EW-1:0] act;
    logic [EW-1:0] mask;
    act  = {1'b0, done, busy, playSound, note_idx};
    mask = exp[EW-1] ? {1'b0, {(EW-1){1'b1}}} : {1'b0, {(EW-1-AW){1'b1}}, {AW{1'b0}}};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s @%0t: got done=%0b busy=%0b playSound=%h note_idx=%0d, expected done=%0b busy=%0b playSound=%h note_idx=%0d",
               name, $time, done, busy, playSound, note_idx,
               exp[EW-2], exp[EW-3], exp[EW-4:AW], exp[AW-1:0]);
    end
  endtask

  task automatic write_entry(input int a, input logic [3:0] n, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_note = n; wr_dur = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  function automatic int note_len(input int i);
    int units;
    units = (tbl[i].dur == '0) ? 1 : int'(tbl[i].dur);
    return 1 + units * TICK + GAP_LEN;
  endfunction

  task automatic push_trace(input int n, input int passes);
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < n; i++) begin
        int units;
        units = (tbl[i].dur == '0) ? 1 : int'(tbl[i].dur);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 13'h0, i));
        for (int c = 0; c < units * TICK; c++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, tbl[i].exp_ps, i));
        for (int c = 0; c < GAP_LEN; c++) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 13'h0, i));
      end
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 13'h0, 0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 0));
  endtask

  // Pulse start (optionally with a same-cycle table write), then compare one
  // queued expectation per cycle. Event hooks fire after a given cycle's check.
  task automatic run_melody(input string name, input logic [AW:0] num, input logic lp,
                            input int last_wr, input int drop_loop_at,
                            input int stop_at, input int poke_at);
    int cyc;
    cyc = 0;
    @(negedge clk);
    num_notes = num; loop = lp; start = 1'b1;
    if (last_wr >= 0) begin
      wr_en = 1'b1; wr_addr = AW'(last_wr);
      wr_note = tbl[last_wr].note; wr_dur = tbl[last_wr].dur;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    while (exp_q.size() > 0) begin
      check_word(name, exp_q.pop_front());
      wr_en = 1'b0; start = 1'b0; stop = 1'b0;
      if (cyc == drop_loop_at) loop = 1'b0;
      if (cyc == poke_at) begin
        wr_en = 1'b1; wr_addr = '0; wr_note = 4'd3; wr_dur = 4'd2;
        start = 1'b1; num_notes = 6'd1;
      end
      if (cyc == stop_at) begin
        stop = 1'b1;
        exp_q.delete();
        repeat (6) exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 13'h0, 0));
      end
      cyc++;
      @(negedge clk);
    end
    wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0;
  endtask

  initial begin
    int pass_len;
    logic [12:0] one;
    one = 13'h1;

    // Reset held low with start asserted: everything stays quiet.
    rst = 1'b0; start = 1'b1; num_notes = 6'd3;
    repeat (3) begin
      @(negedge clk);
      check_word("reset", mk(1'b1, 1'b0, 1'b0, 13'h0, 0));
    end
    start = 1'b0;
    rst = 1'b1;

    // Three-note melody; the last entry is written in the same cycle as start.
    tbl[0] = '{note: 4'd0,  dur: 4'd2, exp_ps: 13'h0001};
    tbl[1] = '{note: 4'd5,  dur: 4'd1, exp_ps: 13'h0020};
    tbl[2] = '{note: 4'd13, dur: 4'd1, exp_ps: 13'h0000};
    write_entry(0, tbl[0].note, tbl[0].dur);
    write_entry(1, tbl[1].note, tbl[1].dur);
    write_entry(2, 4'd7, 4'd5);
    push_trace(3, 1);
    run_melody("basic", 6'd3, 1'b0, 2, -1, -1, -1);

    // Loop once, then drop loop during the final note of the second pass.
    pass_len = note_len(0) + note_len(1) + note_len(2);
    push_trace(3, 2);
    run_melody("loop", 6'd3, 1'b1, -1, 2 * pass_len - 2 - GAP_LEN, -1, -1);

    // Stop during the second note: silence, idle, index 0, no done.
    push_trace(3, 1);
    run_melody("stop", 6'd3, 1'b0, -1, -1, 11 + GAP_LEN, -1);

    // dur==0 acts as 1; writes and start while busy are ignored.
    tbl[0] = '{note: 4'd12, dur: 4'd0, exp_ps: 13'h1000};
    tbl[1] = '{note: 4'd15, dur: 4'd3, exp_ps: 13'h0000};
    write_entry(0, tbl[0].note, tbl[0].dur);
    write_entry(1, tbl[1].note, tbl[1].dur);
    push_trace(2, 1);
    run_melody("busy_poke", 6'd2, 1'b0, -1, -1, -1, 3);
    push_trace(2, 1);
    run_melody("replay", 6'd2, 1'b0, -1, -1, -1, -1);

    // Zero-length start is ignored.
    repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 13'h0, 0));
    run_melody("zero_len", 6'd0, 1'b0, -1, -1, -1, -1);

    // Full table covering every tone code; oversize length clamps to DEPTH.
    for (int i = 0; i < DEPTH; i++) begin
      tbl[i].note   = 4'(i % 16);
      tbl[i].dur    = DW'(i % 3);
      tbl[i].exp_ps = ((i % 16) < 13) ? (one << (i % 16)) : 13'h0;
    end
    for (int i = 0; i < DEPTH; i++) write_entry(i, tbl[i].note, tbl[i].dur);
    push_trace(DEPTH, 1);
    run_melody("tones_clamp", 6'd63, 1'b0, -1, -1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
